// File: rtl/cic_dump_ctrl.sv
// Sequencing controller for a single-DSP48 CIC integrate-and-dump slice.
// Feeds samples as accumulate opcodes, clears P between blocks, and captures one sum per block.
module cic_dump_ctrl #(
  parameter int DSP_LAT   = 4,
  parameter int OPC_DELAY = 1,
  parameter int CNT_W     = 9
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic [CNT_W-1:0] cfg_decim,
  input  logic             s_axis_tvalid,
  input  logic [47:0]      s_axis_tdata,
  output logic             s_axis_tready,
  output logic [47:0]      dsp_concat,
  output logic             dsp_opcode,
  input  logic [47:0]      dsp_p,
  output logic             m_axis_tvalid,
  output logic [47:0]      m_axis_tdata,
  input  logic             m_axis_tready,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     count, decim;
  logic                 accept, last, opc_slot;
  logic [OPC_DELAY-1:0] opc_p;
  logic [DSP_LAT-1:0]   last_p;
  logic                 last_out;

  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    dsp_concat    = '0;
    opc_slot      = 1'b0;
    accept        = 1'b0;
    last          = 1'b0;
    case (state)
      CLEAR: begin
        opc_slot  = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        s_axis_tready = 1'b1;
        accept        = s_axis_tvalid;
        if (accept) begin
          dsp_concat = s_axis_tdata;
          if (count == decim - ONE) begin
            last      = 1'b1;
            state_nxt = CLEAR;
          end
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state <= CLEAR;
      count <= '0;
      decim <= ONE;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        decim <= (cfg_decim == '0) ? ONE : cfg_decim;
        count <= '0;
      end else if (accept && !last) begin
        count <= count + ONE;
      end
    end
  end

  // Opcode path is shorter than the data path inside the slice, so delay it to meet its concat
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      opc_p <= '1;
    end else begin
      opc_p[0] <= opc_slot;
      for (int i = 1; i < OPC_DELAY; i++) opc_p[i] <= opc_p[i-1];
    end
  end

  assign dsp_opcode = opc_p[OPC_DELAY-1];

  // Last-sample tag rides alongside the slice latency; it emerges when P holds the block sum
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      last_p <= '0;
    end else begin
      last_p[0] <= last;
      for (int i = 1; i < DSP_LAT; i++) last_p[i] <= last_p[i-1];
    end
  end

  assign last_out = last_p[DSP_LAT-1];

  // Output register: a stalled sink never blocks input; an unplaceable sum is dropped and flagged
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      overflow      <= 1'b0;
    end else if (last_out) begin
      if (!m_axis_tvalid || m_axis_tready) begin
        m_axis_tdata  <= dsp_p;
        m_axis_tvalid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_dump_ctrl.sv
// Bench for cic_dump_ctrl with a behavioural DSP48 slice model (3-reg data, 2-reg opcode, PREG).
module tb_cic_dump_ctrl;

  logic        clk = 1'b0;
  logic        sync_reset = 1'b1;
  logic [8:0]  cfg_decim = 9'd4;
  logic        s_axis_tvalid = 1'b0;
  logic [47:0] s_axis_tdata = '0;
  logic        s_axis_tready;
  logic [47:0] dsp_concat;
  logic        dsp_opcode;
  logic [47:0] dsp_p;
  logic        m_axis_tvalid;
  logic [47:0] m_axis_tdata;
  logic        m_axis_tready = 1'b1;
  logic        overflow;

  cic_dump_ctrl #(.DSP_LAT(4), .OPC_DELAY(1), .CNT_W(9)) dut (
    .clk(clk), .sync_reset(sync_reset), .cfg_decim(cfg_decim),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tready(s_axis_tready),
    .dsp_concat(dsp_concat), .dsp_opcode(dsp_opcode), .dsp_p(dsp_p),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tready(m_axis_tready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slice model: concat reaches the ALU 3 cycles later, opcode 2 cycles later, P registered after.
  logic [47:0] c1 = '0, c2 = '0, c3 = '0, p = '0;
  logic        o1 = 1'b1, o2 = 1'b1;
  always @(posedge clk) begin
    c1 <= dsp_concat; c2 <= c1; c3 <= c2;
    o1 <= dsp_opcode; o2 <= o1;
    p  <= o2 ? 48'd0 : p + c3;
  end
  assign dsp_p = p;

  logic [47:0] oq_d[$];
  int          oq_c[$];
  always @(negedge clk)
    if (m_axis_tvalid && m_axis_tready) begin
      oq_d.push_back(m_axis_tdata);
      oq_c.push_back(cyc);
    end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [47:0] d, input int gap, output int acc);
    s_axis_tvalid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      chk("gap_concat", dsp_concat, 48'd0);
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    acc = -1;
    for (int k = 0; k < 20 && acc < 0; k++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        chk("acc_concat", dsp_concat, d);
        acc = cyc;
      end
      @(posedge clk); #1;
    end
    if (acc < 0) begin
      total++; bad++;
      $display("FAIL send_timeout: got no tready expected tready within 20 cycles");
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    sync_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_tready", 48'(s_axis_tready), 48'd0);
    chk("rst_opcode", 48'(dsp_opcode), 48'd1);
    chk("rst_concat", dsp_concat, 48'd0);
    chk("rst_tvalid", 48'(m_axis_tvalid), 48'd0);
    chk("rst_tdata", m_axis_tdata, 48'd0);
    chk("rst_overflow", 48'(overflow), 48'd0);
    @(posedge clk); #1;
    sync_reset = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int k = 0; k < 80 && oq_d.size() < n; k++) @(negedge clk);
    chk("out_count", 48'(oq_d.size()), 48'(n));
  endtask

  typedef struct packed {
    logic [8:0]        decim;
    int                gap;
    int                n;
    logic [3:0][47:0]  d;
    logic [47:0]       sum;
  } blk_t;

  function automatic blk_t mk(input int dec, input int gap, input int n,
                              input logic [47:0] a, input logic [47:0] b,
                              input logic [47:0] c, input logic [47:0] e,
                              input logic [47:0] s);
    blk_t r;
    r.decim = 9'(dec);
    r.gap   = gap;
    r.n     = n;
    r.d     = {e, c, b, a};
    r.sum   = s;
    return r;
  endfunction

  localparam int NBLK = 7;
  blk_t tbl[NBLK];
  int   exp_c[NBLK];
  int   acc;

  initial begin
    tbl[0] = mk(4, 0, 4, 48'd1, 48'd2, 48'd3, 48'd4, 48'd10);
    tbl[1] = mk(4, 0, 4, 48'd5, 48'd6, 48'd7, 48'd8, 48'd26);
    tbl[2] = mk(3, 2, 3, -48'sd5, 48'd7, -48'sd1, 48'd0, 48'd1);
    tbl[3] = mk(1, 0, 1, 48'h123, 48'd0, 48'd0, 48'd0, 48'h123);
    tbl[4] = mk(1, 0, 1, 48'h456, 48'd0, 48'd0, 48'd0, 48'h456);
    tbl[5] = mk(0, 0, 1, -48'sd3, 48'd0, 48'd0, 48'd0, 48'hFFFF_FFFF_FFFD);
    tbl[6] = mk(2, 0, 2, 48'h7FFF_FFFF_FFFF, 48'd1, 48'd0, 48'd0, 48'h8000_0000_0000);

    do_reset();
    oq_d.delete(); oq_c.delete();

    // Table of blocks, fed back-to-back; outputs collected by the monitor
    for (int i = 0; i < NBLK; i++) begin
      cfg_decim = tbl[i].decim;
      for (int j = 0; j < tbl[i].n; j++) send(tbl[i].d[j], tbl[i].gap, acc);
      exp_c[i] = acc + 5;
      @(negedge clk);
      chk("bubble_tready", 48'(s_axis_tready), 48'd0);
    end
    wait_out(NBLK);
    for (int i = 0; i < NBLK && i < oq_d.size(); i++) begin
      chk("blk_sum", oq_d[i], tbl[i].sum);
      chk("blk_latency", 48'(oq_c[i]), 48'(exp_c[i]));
    end

    // Output stalled across three decim=2 blocks
    cfg_decim = 9'd2;
    do_reset();
    oq_d.delete(); oq_c.delete();
    m_axis_tready = 1'b0;
    for (int j = 0; j < 6; j++) send(48'd1, 0, acc);
    repeat (12) @(negedge clk);
    chk("stall_tvalid", 48'(m_axis_tvalid), 48'd1);
    chk("stall_tdata", m_axis_tdata, 48'd2);
    chk("stall_overflow", 48'(overflow), 48'd1);
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_drain_tvalid", 48'(m_axis_tvalid), 48'd0);
    chk("stall_drain_count", 48'(oq_d.size()), 48'd1);
    if (oq_d.size() > 0) chk("stall_drain_data", oq_d[0], 48'd2);
    chk("stall_overflow_sticky", 48'(overflow), 48'd1);

    // Decimation change mid-block applies at the next clear
    cfg_decim = 9'd4;
    do_reset();
    oq_d.delete(); oq_c.delete();
    send(48'd1, 0, acc);
    send(48'd1, 0, acc);
    cfg_decim = 9'd2;
    for (int j = 0; j < 6; j++) send(48'd1, 0, acc);
    wait_out(3);
    if (oq_d.size() >= 3) begin
      chk("cfg_out0", oq_d[0], 48'd4);
      chk("cfg_out1", oq_d[1], 48'd2);
      chk("cfg_out2", oq_d[2], 48'd2);
    end

    // Reset in the middle of a block discards the partial sum
    cfg_decim = 9'd4;
    do_reset();
    repeat (3) @(negedge clk);
    oq_d.delete(); oq_c.delete();
    @(posedge clk); #1;
    send(48'd5, 0, acc);
    send(48'd5, 0, acc);
    do_reset();
    for (int j = 0; j < 4; j++) send(48'd3, 0, acc);
    repeat (15) @(negedge clk);
    chk("abort_count", 48'(oq_d.size()), 48'd1);
    if (oq_d.size() > 0) chk("abort_sum", oq_d[0], 48'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cic_dump_ctrl.md
# cic_dump_ctrl

Sequencing controller for the single-DSP48 CIC integrate-and-dump slice (accumulate/clear opcodes, 48-bit concat operand, 48-bit P result). It accepts an AXI-Stream sample stream and counts samples per decimation block. It issues accumulate or clear opcodes aligned to the slice's internal pipeline, then captures the block sum from P and presents one decimated output per block. It sits between the channel sample stream and the per-channel CIC output FIFO.

## Interface
Parameters:
- DSP_LAT, 4: cycles from concat presented to P valid (input reg + AREG=2 + PREG)
- OPC_DELAY, 1: cycles opcode is driven after its matching concat (opcode path is 2 regs vs 3 on data)
- CNT_W, 9: width of decimation counter / cfg_decim

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- sync_reset  in  1  synchronous active-high reset
- cfg_decim  in  CNT_W  samples per block; 0 treated as 1; sampled only at block boundary
- s_axis_tvalid  in  1  input sample valid
- s_axis_tdata  in  48  sign-extended input sample
- s_axis_tready  out  1  input ready
- dsp_concat  out  48  slice operand (A:B)
- dsp_opcode  out  1  0 = accumulate (P += A:B), 1 = clear (P = 0)
- dsp_p  in  48  slice result
- m_axis_tvalid  out  1  block sum valid
- m_axis_tdata  out  48  block sum
- m_axis_tready  in  1  downstream ready
- overflow  out  1  sticky; an output was dropped

## Operation
- FSM states: CLEAR, RUN. Reset enters CLEAR.
- CLEAR (1 cycle):
  - s_axis_tready=0, dsp_concat=0, opcode slot=1.
  - Latch decim = max(cfg_decim,1); count=0.
  - Go to RUN.
- RUN:
  - s_axis_tready=1.
  - Accepted sample: dsp_concat=tdata, opcode slot=0, count++.
  - Cycle with no sample: dsp_concat=0, opcode slot=0 (P holds).
  - If the accepted sample has count==decim-1: mark it "last" and go to CLEAR.
- Opcode slot is delayed OPC_DELAY cycles onto dsp_opcode via a shift register. The shift register resets to 1.
- "Last" tag travels through a DSP_LAT-deep shift register (reset 0). When the tag emerges, dsp_p is the block sum.
- Capture:
  - If m_axis_tvalid==0 or m_axis_tready==1: load m_axis_tdata=dsp_p, m_axis_tvalid=1.
  - Otherwise keep the held data, drop the new sum, set overflow=1 (cleared only by reset).
- m_axis_tvalid falls after a handshake with no coincident capture.
- Arithmetic: 48-bit two's complement, wraps modulo 2^48, no saturation. The controller does not widen or truncate.
- cfg_decim changes mid-block take effect at the next CLEAR.
- Output stall never backpressures input. With decim=1, input throughput is 1 sample per 2 cycles.

## Timing
- Reset values:
  - s_axis_tready=0, dsp_concat=0, dsp_opcode=1.
  - m_axis_tvalid=0, m_axis_tdata=0, overflow=0.
  - count=0, tag line all 0.
- Alignment: concat at cycle t and dsp_opcode at t+OPC_DELAY act on the same ALU cycle. The result is on dsp_p at t+DSP_LAT.
- Clear bubble: one cycle with tready=0 after each block's last sample. The clear concat slot is at t+1 and P=0 at t+5; the next sample can be accepted at t+2.
- Latency: last sample accepted at cycle t → m_axis_tvalid=1 at t+DSP_LAT+1 (t+5 with defaults).
- Reset mid-block: partial sum is discarded and in-flight tags are flushed, so no spurious output. The first cycle after reset release is CLEAR.
- Simultaneous handshake and capture: new data loads, tvalid stays 1, no overflow.

## Test plan
- decim=4; samples 1..8 back-to-back, tready=1 → outputs 10 then 26; each m_axis_tvalid exactly 5 cycles after the 4th/8th accept; tready low one cycle after each block.
- decim=3; samples -5,7,-1 with 2-cycle tvalid gaps → output 1 (48-bit); P unchanged during gaps.
- decim=1; constant tvalid, data 0x123,0x456 → outputs 0x123, 0x456; s_axis_tready toggles 1,0.
- decim=2, m_axis_tready=0 for 3 blocks (samples all 1) → first output 2 held; overflow=1 after second capture; after tready=1, output is 2, not 4 or 6.
- cfg_decim changed 4→2 after 2nd sample of a block; samples all 1 → outputs 4, then 2, 2.
- sync_reset asserted after 2 of 4 samples, then 4 samples of 3 → single output 12; no output from the aborted block; dsp_opcode=1 during reset.
